ccr_flag_unit: RTL and testbench
================================

Name: ccr_flag_unit

Overview:
- Condition-code register (CCR) directly downstream of the execute-stage ALU.
- Captures the ALU's flags_out, holds the architectural Z/N/C flags and feeds them back as the ALU's flags_in.
- Resolves conditional jumps against the current flags and clears the tested flag when a jump is taken.
- Saves and restores flags on interrupt entry and RTI using a small shadow stack.

Parameters:
- FLAG_W, 4, flag vector width. Bit 0 = Z, bit 1 = N, bit 2 = C, bit 3 reserved.
- SHADOW_DEPTH, 2, number of shadow-stack entries (nested interrupt depth). Minimum 1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- alu_flags  in  FLAG_W  flags_out from the ALU for the instruction currently in execute.
- flags_we  in  1  execute-stage instruction updates flags (add, sub, and, not, setc).
- stall  in  1  pipeline stall; hold all state.
- flush  in  1  squash the execute-stage instruction this cycle.
- br_valid  in  1  a branch is being resolved this cycle.
- br_type  in  2  00 = JMP (unconditional), 01 = JZ, 10 = JN, 11 = JC.
- int_save  in  1  interrupt entry: push flags.
- rti_restore  in  1  RTI: pop flags.
- flags_q  out  FLAG_W  registered CCR value, to ALU flags_in.
- br_taken  out  1  combinational branch decision.
- stk_cnt  out  $clog2(SHADOW_DEPTH+1)  number of occupied shadow-stack entries.
- stk_err  out  1  sticky: overflow or underflow occurred.

Behaviour:
- Reset: asynchronous on reset_b low. flags_q = 0, stk_cnt = 0, stk_err = 0, all shadow entries = 0. Reset mid-operation discards any pending push or pop.
- Effective flags (combinational forwarding): eff = (flags_we & ~flush) ? alu_flags : flags_q. Bit 3 is always forced to 0 in eff.
- br_taken:
  - Equals br_valid & ~flush & (JMP | (JZ & eff[0]) | (JN & eff[1]) | (JC & eff[2])).
  - No latency; valid in the same cycle.
  - br_taken is still computed during a stall, but no state changes while stall is high.
- Next-flags value, when not stalled:
  - nxt = eff.
  - If br_taken and br_type != JMP, the tested bit in nxt is cleared (JZ clears Z, JN clears N, JC clears C).
- Update priority when not stalled, highest first:
  1. rti_restore:
     - If stk_cnt > 0: flags_q <= top of stack, stk_cnt decrements.
     - If stk_cnt == 0 (underflow): flags_q <= nxt and stk_err <= 1.
  2. int_save:
     - If stk_cnt < SHADOW_DEPTH: push nxt, stk_cnt increments, flags_q <= nxt.
     - If full (overflow): no push, stk_err <= 1, flags_q <= nxt.
  3. Otherwise: flags_q <= nxt.
- int_save and rti_restore asserted together: rti_restore wins; int_save is dropped and stk_err <= 1.
- Latency: flags written in cycle N appear on flags_q in cycle N+1. Consumers see them in cycle N through the eff forwarding path.
- flush: suppresses flags_we and br_taken only. Stack operations are still honoured, because the interrupt controller owns flush timing.
- stall: everything holds, including the stack and stk_err.
- stk_err clears only on reset.

Optional Feature:
- Macro: CCR_BRANCH_CNT_EN.
- When defined:
  - Adds output br_cnt, 16 bits.
  - br_cnt increments on each non-stalled cycle with br_taken = 1.
  - br_cnt saturates at 16'hFFFF and resets to 0.
- When not defined: no port, no counter logic.

Decomposition:
- Shared package ccr_pkg:
  - Flag index constants FLG_Z = 0, FLG_N = 1, FLG_C = 2.
  - Branch-type constants BR_JMP, BR_JZ, BR_JN, BR_JC.
- Sub-module: flag_shadow_stack (LIFO of SHADOW_DEPTH × FLAG_W, with push/pop/cnt/err).
- Branch evaluation and flag-clear logic stay in the top level.

Test Plan:
- Reset: drive reset_b low mid-stream with stk_cnt = 1 -> flags_q = 0, stk_cnt = 0, stk_err = 0 asynchronously, without waiting for a clock edge.
- Forwarding and clear: flags_we = 1, alu_flags = 4'b0001, br_valid = 1, br_type = JZ in the same cycle -> br_taken = 1 in that cycle; next cycle flags_q = 4'b0000.
- Not taken: flags_q = 4'b0100, br_type = JN -> br_taken = 0 and flags_q unchanged. Then br_type = JC -> br_taken = 1 and flags_q becomes 4'b0000.
- Nested interrupts:
  - flags_q = 4'b0110 -> int_save.
  - Set flags to 4'b0001 -> int_save.
  - Set flags to 4'b0000 -> rti_restore gives 4'b0001 -> rti_restore gives 4'b0110.
  - stk_cnt sequence 1, 2, 1, 0; stk_err stays 0.
- Overflow and underflow: three int_save pulses with SHADOW_DEPTH = 2 -> stk_cnt stays at 2 and stk_err = 1. After reset, rti_restore on an empty stack -> stk_err = 1 and flags_q unchanged.
- Stall and flush:
  - stall = 1 with flags_we = 1, alu_flags = 4'b0111 -> flags_q held.
  - flush = 1 with flags_we = 1, br_valid = 1, br_type = JMP -> br_taken = 0 and flags_q unchanged.
  - With CCR_BRANCH_CNT_EN defined: 3 taken branches -> br_cnt = 3.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared flag-bit indices and branch-type encodings for the condition-code register.
package ccr_pkg;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;

    typedef enum logic [1:0] {
        BR_JMP = 2'b00,
        BR_JZ  = 2'b01,
        BR_JN  = 2'b10,
        BR_JC  = 2'b11
    } br_type_e;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved flag vectors for nested interrupts; top entry visible combinationally.
// One push or pop per enabled cycle; pop wins over push, and misuse sets a sticky error.
module flag_shadow_stack #(
    parameter  int DEPTH = 2,
    parameter  int W     = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_dat,
    output logic [W-1:0]  top_dat,
    output logic [CW-1:0] cnt,
    output logic          err
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_empty;
    logic          w_full;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign cnt     = r_cnt;
    assign err     = r_err;

    always_comb begin
        top_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_cnt == CW'(i + 1)) begin
                top_dat = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (en) begin
            if (pop) begin
                // A push arriving with the pop is dropped and flagged.
                if (!w_empty) begin
                    r_cnt <= r_cnt - CW'(1);
                end
                if (w_empty || push) begin
                    r_err <= 1'b1;
                end
            end else if (push) begin
                if (!w_full) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_mem[i] <= push_dat;
                        end
                    end
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ccr_flag_unit.sv
// Condition-code register after the ALU: forwards flags, resolves branches, saves/restores on interrupts.
// br_taken is same-cycle; flags_q updates one cycle later; stall freezes all state.
// Optional CCR_BRANCH_CNT_EN adds a saturating 16-bit taken-branch counter on br_cnt.
module ccr_flag_unit
    import ccr_pkg::*;
#(
    parameter  int FLAG_W       = 4,
    parameter  int SHADOW_DEPTH = 2,
    localparam int CNT_W        = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flags_we,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic [FLAG_W-1:0] flags_q,
    output logic              br_taken,
    output logic [CNT_W-1:0]  stk_cnt,
    output logic              stk_err
`ifdef CCR_BRANCH_CNT_EN
    ,
    output logic [15:0]       br_cnt
`endif
);

    localparam logic [FLAG_W-1:0] FLG_MASK = FLAG_W'(3'b111);

    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] w_eff;
    logic [FLAG_W-1:0] w_nxt;
    logic [FLAG_W-1:0] w_top;
    logic              w_hit;

    // Reserved bits never reach the architectural state.
    assign w_eff = ((flags_we && !flush) ? alu_flags : r_flags) & FLG_MASK;

    always_comb begin
        w_hit = 1'b0;
        w_nxt = w_eff;
        case (br_type_e'(br_type))
            BR_JMP:  w_hit = 1'b1;
            BR_JZ:   w_hit = w_eff[FLG_Z];
            BR_JN:   w_hit = w_eff[FLG_N];
            BR_JC:   w_hit = w_eff[FLG_C];
            default: w_hit = 1'b0;
        endcase
        br_taken = br_valid && !flush && w_hit;
        if (br_taken) begin
            case (br_type_e'(br_type))
                BR_JZ:   w_nxt[FLG_Z] = 1'b0;
                BR_JN:   w_nxt[FLG_N] = 1'b0;
                BR_JC:   w_nxt[FLG_C] = 1'b0;
                default: w_nxt = w_eff;
            endcase
        end
    end

    flag_shadow_stack #(
        .DEPTH (SHADOW_DEPTH),
        .W     (FLAG_W)
    ) u_stack (
        .clk      (clk),
        .reset_b  (reset_b),
        .en       (!stall),
        .push     (int_save),
        .pop      (rti_restore),
        .push_dat (w_nxt),
        .top_dat  (w_top),
        .cnt      (stk_cnt),
        .err      (stk_err)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_flags <= '0;
        end else if (!stall) begin
            if (rti_restore && (stk_cnt != '0)) begin
                r_flags <= w_top;
            end else begin
                r_flags <= w_nxt;
            end
        end
    end

    assign flags_q = r_flags;

`ifdef CCR_BRANCH_CNT_EN
    logic [15:0] r_br_cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_br_cnt <= '0;
        end else if (!stall && br_taken && (r_br_cnt != 16'hFFFF)) begin
            r_br_cnt <= r_br_cnt + 16'd1;
        end
    end

    assign br_cnt = r_br_cnt;
`endif

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Directed bench for ccr_flag_unit with an abstract flag/stack model checked every cycle.
module tb_ccr_flag_unit;

    logic       clk = 1'b0;
    logic       reset_b = 1'b1;
    logic [3:0] alu_flags;
    logic       flags_we, stall, flush, br_valid, int_save, rti_restore;
    logic [1:0] br_type;
    logic [3:0] flags_q;
    logic       br_taken;
    logic [1:0] stk_cnt;
    logic       stk_err;
`ifdef CCR_BRANCH_CNT_EN
    logic [15:0] br_cnt;
`endif

    ccr_flag_unit dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .alu_flags   (alu_flags),
        .flags_we    (flags_we),
        .stall       (stall),
        .flush       (flush),
        .br_valid    (br_valid),
        .br_type     (br_type),
        .int_save    (int_save),
        .rti_restore (rti_restore),
        .flags_q     (flags_q),
        .br_taken    (br_taken),
        .stk_cnt     (stk_cnt),
        .stk_err     (stk_err)
`ifdef CCR_BRANCH_CNT_EN
        ,
        .br_cnt      (br_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: flags as a 4-bit value, shadow stack as a 2-slot array plus depth.
    logic [3:0] m_flags;
    logic [3:0] m_stk [2];
    int         m_sp;
    logic       m_err;
    int         m_brc;

    function automatic logic [3:0] m_eff();
        return ((flags_we && !flush) ? alu_flags : m_flags) & 4'b0111;
    endfunction

    function automatic logic m_taken();
        logic [3:0] e;
        e = m_eff();
        if (!br_valid || flush) return 1'b0;
        if (br_type == 2'd0) return 1'b1;
        return e[int'(br_type) - 1];
    endfunction

    function automatic logic [3:0] m_next();
        logic [3:0] n;
        n = m_eff();
        if (m_taken() && br_type != 2'd0) n[int'(br_type) - 1] = 1'b0;
        return n;
    endfunction

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_flags <= 4'd0;
            m_sp    <= 0;
            m_err   <= 1'b0;
            m_brc   <= 0;
            m_stk[0] <= 4'd0;
            m_stk[1] <= 4'd0;
        end else if (!stall) begin
            if (m_taken() && m_brc < 65535) m_brc <= m_brc + 1;
            if (rti_restore) begin
                if (m_sp > 0) begin
                    m_flags <= m_stk[m_sp - 1];
                    m_sp    <= m_sp - 1;
                end else begin
                    m_flags <= m_next();
                    m_err   <= 1'b1;
                end
                if (int_save) m_err <= 1'b1;
            end else if (int_save) begin
                if (m_sp < 2) begin
                    m_stk[m_sp] <= m_next();
                    m_sp        <= m_sp + 1;
                end else begin
                    m_err <= 1'b1;
                end
                m_flags <= m_next();
            end else begin
                m_flags <= m_next();
            end
        end
    end

    // Hand-computed expectations for the current cycle; -1 means "not pinned".
    logic  chk_en = 1'b0;
    logic  pin_vld = 1'b0;
    string pin_name = "";
    int    pin_flags, pin_cnt, pin_err, pin_tk, pin_brc;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("flags_q", int'(flags_q), int'(m_flags));
            cmp("stk_cnt", int'(stk_cnt), m_sp);
            cmp("stk_err", int'(stk_err), int'(m_err));
            cmp("br_taken", int'(br_taken), int'(m_taken()));
`ifdef CCR_BRANCH_CNT_EN
            cmp("br_cnt", int'(br_cnt), m_brc);
`endif
            if (pin_vld) begin
                if (pin_flags >= 0) begin
                    cmp({pin_name, "/flags_q"}, int'(flags_q), pin_flags);
                    cmp({pin_name, "/model_flags"}, int'(m_flags), pin_flags);
                end
                if (pin_cnt >= 0) cmp({pin_name, "/stk_cnt"}, int'(stk_cnt), pin_cnt);
                if (pin_err >= 0) cmp({pin_name, "/stk_err"}, int'(stk_err), pin_err);
                if (pin_tk >= 0) cmp({pin_name, "/br_taken"}, int'(br_taken), pin_tk);
`ifdef CCR_BRANCH_CNT_EN
                if (pin_brc >= 0) cmp({pin_name, "/br_cnt"}, int'(br_cnt), pin_brc);
`endif
            end
        end
    end

    task automatic idle();
        alu_flags = 4'd0; flags_we = 1'b0; stall = 1'b0; flush = 1'b0;
        br_valid = 1'b0; br_type = 2'd0; int_save = 1'b0; rti_restore = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        pin_vld = 1'b0;
        idle();
    endtask

    task automatic pin(input string nm, input int f, input int c, input int e, input int t);
        pin_vld = 1'b1; pin_name = nm;
        pin_flags = f; pin_cnt = c; pin_err = e; pin_tk = t; pin_brc = -1;
    endtask

    task automatic wr(input logic [3:0] v);
        flags_we = 1'b1; alu_flags = v;
    endtask

    task automatic br(input logic [1:0] t);
        br_valid = 1'b1; br_type = t;
    endtask

    initial begin
        idle();
        #1 reset_b = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        pin("reset", 0, 0, 0, 0);
        tick(); reset_b = 1'b1;

        // Forwarding and Z clear
        tick(); wr(4'b0010);
        tick(); wr(4'b0001); br(2'b01); pin("fwd_jz", 2, 0, 0, 1);
        tick(); wr(4'b0100); pin("jz_clear", 0, 0, 0, 0);
        tick(); br(2'b10); pin("jn_not", 4, 0, 0, 0);
        tick(); br(2'b11); pin("jc_taken", 4, 0, 0, 1);
        tick(); pin("jc_clear", 0, 0, 0, 0);

        // Nested interrupts
        tick(); wr(4'b0110);
        tick(); int_save = 1'b1; pin("pre_save1", 6, 0, 0, 0);
        tick(); wr(4'b0001); pin("save1", 6, 1, 0, 0);
        tick(); int_save = 1'b1; pin("pre_save2", 1, 1, 0, 0);
        tick(); wr(4'b0000); pin("save2", 1, 2, 0, 0);
        tick(); rti_restore = 1'b1; pin("pre_rti1", 0, 2, 0, 0);
        tick(); rti_restore = 1'b1; pin("rti1", 1, 1, 0, 0);
        tick(); pin("rti2", 6, 0, 0, 0);

        // Overflow
        tick(); int_save = 1'b1;
        tick(); int_save = 1'b1; pin("ovf1", 6, 1, 0, 0);
        tick(); int_save = 1'b1; pin("ovf2", 6, 2, 0, 0);
        tick(); pin("overflow", 6, 2, 1, 0);

        // Stall and flush
        tick(); stall = 1'b1; wr(4'b0111); rti_restore = 1'b1; br(2'b00); pin("stall_tk", 6, 2, 1, 1);
        tick(); pin("stall_hold", 6, 2, 1, 0);
        tick(); flush = 1'b1; wr(4'b0111); br(2'b00); pin("flush_br", 6, 2, 1, 0);
        tick(); flush = 1'b1; rti_restore = 1'b1; pin("flush_hold", 6, 2, 1, 0);
        tick(); pin("flush_rti", 6, 1, 1, 0);

        // Asynchronous reset with one entry stacked
        tick(); reset_b = 1'b0; pin("async_rst", 0, 0, 0, 0);
        tick();
        tick(); reset_b = 1'b1;

        // Reserved-bit masking, then save and restore in the same cycle
        tick(); wr(4'b1101);
        tick(); int_save = 1'b1; pin("mask", 5, 0, 0, 0);
        tick(); wr(4'b0010); int_save = 1'b1; rti_restore = 1'b1; pin("pre_both", 5, 1, 0, 0);
        tick(); pin("both", 5, 0, 1, 0);

        // Underflow on a fresh stack
        tick(); reset_b = 1'b0;
        tick(); reset_b = 1'b1;
        tick(); wr(4'b0101);
        tick(); rti_restore = 1'b1; pin("pre_under", 5, 0, 0, 0);
        tick(); pin("underflow", 5, 0, 1, 0);

        // JMP leaves flags intact; stalled branches are not counted
        tick(); reset_b = 1'b0;
        tick(); reset_b = 1'b1;
        tick(); wr(4'b0111);
        tick(); br(2'b00); pin("jmp1", 7, 0, 0, 1);
        tick(); br(2'b00);
        tick(); br(2'b00); stall = 1'b1;
        tick(); br(2'b00);
        tick(); pin("jmp_done", 7, 0, 0, 0); pin_brc = 3;
        tick();

        chk_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
